multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the 4-bit CPU. Each instruction runs over several clocks.
//  It sequences the shared PC/IR/ALU/register-file/memory datapath: fetch, decode, execute, mem, writeback.
//  It drives all datapath selects and the memory req/ready handshake, and flags HALT, illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the 4-bit multi-cycle CPU.
// Sequences the shared PC/IR/ALU/register-file/memory datapath through
// fetch, decode, execute, memory and writeback. Drives every datapath
// select and the memory req/ready handshake. Flags HALT, illegal opcodes
// and memory timeouts with sticky status outputs.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] alucontrol,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       halted,
    output logic [1:0] err_code
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Wait counter only ever needs to reach TIMEOUT-1.
    localparam int              CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_next;
    logic          halted_q, halted_next;
    logic [1:0]    err_q, err_next;
    logic          pcwrite, pcwritecond;

    // ALU operation for R-type instructions in EXEC.
    function automatic logic [3:0] rtype_alu(input logic [3:0] opcode);
        case (opcode)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // State, wait counter and sticky status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            halted_q <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state    <= state_next;
            wait_cnt <= wait_next;
            halted_q <= halted_next;
            err_q    <= err_next;
        end
    end

    // Next-state and control outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_next  = state;
        err_next    = err_q;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcsource    = 2'b00;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        alucontrol  = ALU_ADD;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;

        // NOTE: decoding is gated by reset_n so that asserting reset drops
        // mem_req and all enables at once, without waiting for a clock edge.
        if (reset_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    if (mem_ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        state_next = S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_next = S_ERR;
                        err_next   = ERR_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch target into ALUOut.
                    alusrcb = 2'b11;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_next = S_EXEC;
                        OP_ADDI:     state_next = S_ADDIEX;
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_BEQ:      state_next = S_BRANCH;
                        OP_J:        state_next = S_JUMP;
                        OP_HALT:     state_next = S_HALT;
                        default: begin
                            state_next = S_ERR;
                            err_next   = ERR_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC: begin
                    alusrca    = 1'b1;
                    alucontrol = rtype_alu(op);
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_ADDIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD, S_MEMWR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (state == S_MEMWR);
                    if (mem_ready) begin
                        state_next = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_next = S_ERR;
                        err_next   = ERR_TIMEOUT;
                    end
                end
                S_MEMWB: begin
                    memtoreg   = 1'b1;
                    regwrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    alucontrol  = ALU_SUB;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                    state_next  = S_FETCH;
                end
                S_JUMP: begin
                    pcwrite    = 1'b1;
                    pcsource   = 2'b10;
                    state_next = S_FETCH;
                end
                S_HALT:  state_next = S_HALT;
                S_ERR:   state_next = S_ERR;
                default: state_next = S_ERR;
            endcase
        end

        pcen = pcwrite | (pcwritecond & zero);

        // Count stalled request cycles; clear on completion or state change.
        if (mem_req && !mem_ready && (state_next == state)) begin
            wait_next = wait_cnt + CW'(1);
        end else begin
            wait_next = '0;
        end

        halted_next = halted_q | (state_next == S_HALT);
    end

    assign halted   = halted_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed per-cycle instruction sequences.
// The stimulus process queues the expected control vector for every cycle
// it drives; an independent monitor pops and compares on the falling edge.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsource;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] alucontrol;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       halted;
        logic [1:0] err_code;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] op = 4'b0000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, irwrite, pcen;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] alucontrol;
    logic       regdst, memtoreg, regwrite, halted;
    logic [1:0] err_code;

    ctrl_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    release_pending = 1'b0;

    logic [3:0] r_ops[5];
    logic [3:0] r_alu[5];

    multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .pcsource   (pcsource),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .halted     (halted),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Hand-written expected control vectors, one per datapath step.
    function automatic ctrl_t e_idle();
        ctrl_t c;
        c = '0;
        c.alucontrol = 4'b0010;
        return c;
    endfunction

    function automatic ctrl_t e_fetch(input logic rdy);
        ctrl_t c;
        c = e_idle();
        c.mem_req = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = rdy;
        c.pcen    = rdy;
        return c;
    endfunction

    function automatic ctrl_t e_decode();
        ctrl_t c;
        c = e_idle();
        c.alusrcb = 2'b11;
        return c;
    endfunction

    function automatic ctrl_t e_exec(input logic [3:0] alu);
        ctrl_t c;
        c = e_idle();
        c.alusrca    = 1'b1;
        c.alucontrol = alu;
        return c;
    endfunction

    function automatic ctrl_t e_aluwb();
        ctrl_t c;
        c = e_idle();
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t e_immex();
        ctrl_t c;
        c = e_idle();
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        return c;
    endfunction

    function automatic ctrl_t e_addiwb();
        ctrl_t c;
        c = e_idle();
        c.regwrite = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t e_mem(input logic we);
        ctrl_t c;
        c = e_idle();
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = we;
        return c;
    endfunction

    function automatic ctrl_t e_memwb();
        ctrl_t c;
        c = e_idle();
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t e_branch(input logic z);
        ctrl_t c;
        c = e_idle();
        c.alusrca    = 1'b1;
        c.alucontrol = 4'b0110;
        c.pcsource   = 2'b01;
        c.pcen       = z;
        return c;
    endfunction

    function automatic ctrl_t e_jump();
        ctrl_t c;
        c = e_idle();
        c.pcen     = 1'b1;
        c.pcsource = 2'b10;
        return c;
    endfunction

    function automatic ctrl_t e_halt();
        ctrl_t c;
        c = e_idle();
        c.halted = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t e_err(input logic [1:0] code);
        ctrl_t c;
        c = e_idle();
        c.err_code = code;
        return c;
    endfunction

    // Drive one clock's inputs just after the rising edge and queue the
    // outputs expected for that clock.
    task automatic step(input logic [3:0] o, input logic z, input logic rdy,
                        input ctrl_t e, input string nm);
        @(posedge clk);
        #1;
        if (release_pending) begin
            reset_n = 1'b1;
            release_pending = 1'b0;
        end
        op = o;
        zero = z;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One clock in reset (ready high, which must be ignored); the next
    // step() releases it.
    task automatic apply_reset(input string nm);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        mem_ready = 1'b1;
        exp_q.push_back(e_idle());
        name_q.push_back(nm);
        release_pending = 1'b1;
    endtask

    task automatic fetch(input logic [3:0] o, input int waits);
        for (int i = 0; i < waits; i++) step(o, 1'b0, 1'b0, e_fetch(1'b0), "fetch_wait");
        step(o, 1'b0, 1'b1, e_fetch(1'b1), "fetch_ready");
    endtask

    // Compare the DUT against the oldest queued expectation on each falling edge.
    always @(negedge clk) begin
        ctrl_t act;
        ctrl_t exp_v;
        string nm;
        if (exp_q.size() > 0) begin
            act = {mem_req, mem_we, iord, irwrite, pcen, pcsource, alusrca, alusrcb,
                   alucontrol, regdst, memtoreg, regwrite, halted, err_code};
            exp_v = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL %s: got %05h expected %05h (t=%0t)", nm, act, exp_v, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        r_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
        r_alu = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

        apply_reset("reset_state");

        // ADD, zero wait; ready high outside memory states must be ignored.
        fetch(OP_ADD, 0);
        step(OP_ADD, 1'b0, 1'b1, e_decode(), "add_decode");
        step(OP_ADD, 1'b0, 1'b1, e_exec(4'b0010), "add_exec");
        step(OP_ADD, 1'b0, 1'b1, e_aluwb(), "add_aluwb");

        // All R-type ops, one fetch wait each.
        for (int i = 0; i < 5; i++) begin
            fetch(r_ops[i], 1);
            step(r_ops[i], 1'b0, 1'b0, e_decode(), "rtype_decode");
            step(r_ops[i], 1'b0, 1'b0, e_exec(r_alu[i]), "rtype_exec_alu");
            step(r_ops[i], 1'b0, 1'b0, e_aluwb(), "rtype_aluwb");
        end

        // ADDI.
        fetch(OP_ADDI, 0);
        step(OP_ADDI, 1'b0, 1'b0, e_decode(), "addi_decode");
        step(OP_ADDI, 1'b0, 1'b0, e_immex(), "addi_ex");
        step(OP_ADDI, 1'b0, 1'b0, e_addiwb(), "addi_wb");

        // LW with 3 wait cycles in FETCH and MEMRD: 11 clocks.
        fetch(OP_LW, 3);
        step(OP_LW, 1'b0, 1'b0, e_decode(), "lw_decode");
        step(OP_LW, 1'b0, 1'b0, e_immex(), "lw_memadr");
        for (int i = 0; i < 3; i++) step(OP_LW, 1'b0, 1'b0, e_mem(1'b0), "lw_memrd_wait");
        step(OP_LW, 1'b0, 1'b1, e_mem(1'b0), "lw_memrd_ready");
        step(OP_LW, 1'b0, 1'b0, e_memwb(), "lw_memwb");

        // SW, zero wait.
        fetch(OP_SW, 0);
        step(OP_SW, 1'b0, 1'b0, e_decode(), "sw_decode");
        step(OP_SW, 1'b0, 1'b0, e_immex(), "sw_memadr");
        step(OP_SW, 1'b0, 1'b1, e_mem(1'b1), "sw_memwr_ready");

        // BEQ taken, then not taken (zero high elsewhere must not matter).
        fetch(OP_BEQ, 0);
        step(OP_BEQ, 1'b0, 1'b0, e_decode(), "beq_decode");
        step(OP_BEQ, 1'b1, 1'b0, e_branch(1'b1), "beq_taken");
        fetch(OP_BEQ, 0);
        step(OP_BEQ, 1'b1, 1'b0, e_decode(), "beq_decode");
        step(OP_BEQ, 1'b0, 1'b0, e_branch(1'b0), "beq_not_taken");

        // J.
        fetch(OP_J, 0);
        step(OP_J, 1'b0, 1'b0, e_decode(), "j_decode");
        step(OP_J, 1'b0, 1'b0, e_jump(), "j_jump");

        // SW with ready on the 16th request cycle: normal completion.
        fetch(OP_SW, 0);
        step(OP_SW, 1'b0, 1'b0, e_decode(), "sw16_decode");
        step(OP_SW, 1'b0, 1'b0, e_immex(), "sw16_memadr");
        for (int i = 0; i < TIMEOUT - 1; i++) step(OP_SW, 1'b0, 1'b0, e_mem(1'b1), "sw16_wait");
        step(OP_SW, 1'b0, 1'b1, e_mem(1'b1), "sw16_ready");
        fetch(OP_J, 0);
        step(OP_J, 1'b0, 1'b0, e_decode(), "after_sw16_decode");

        // SW with ready never arriving: ERR after 16 request cycles.
        step(OP_J, 1'b0, 1'b0, e_jump(), "after_sw16_jump");
        fetch(OP_SW, 0);
        step(OP_SW, 1'b0, 1'b0, e_decode(), "swto_decode");
        step(OP_SW, 1'b0, 1'b0, e_immex(), "swto_memadr");
        for (int i = 0; i < TIMEOUT; i++) step(OP_SW, 1'b0, 1'b0, e_mem(1'b1), "swto_wait");
        for (int i = 0; i < 3; i++) step(OP_SW, 1'b0, 1'b1, e_err(2'b10), "swto_err");
        apply_reset("reset_clears_timeout");

        // Illegal opcodes.
        fetch(4'b1010, 0);
        step(4'b1010, 1'b0, 1'b0, e_decode(), "ill_decode");
        for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, 1'b1, e_err(2'b01), "ill_err");
        apply_reset("reset_clears_illegal");
        fetch(4'b1110, 0);
        step(4'b1110, 1'b0, 1'b0, e_decode(), "ill2_decode");
        step(4'b1110, 1'b0, 1'b0, e_err(2'b01), "ill2_err");
        apply_reset("reset_clears_illegal2");

        // HALT: absorbing for 20 clocks, mem_req stays low despite ready.
        fetch(OP_HALT, 0);
        step(OP_HALT, 1'b0, 1'b0, e_decode(), "halt_decode");
        for (int i = 0; i < 20; i++) step(OP_HALT, 1'b0, 1'(i % 2), e_halt(), "halt_hold");
        apply_reset("reset_clears_halt");

        // Reset pulsed mid-MEMRD, away from the clock edge.
        fetch(OP_LW, 0);
        step(OP_LW, 1'b0, 1'b0, e_decode(), "rst_lw_decode");
        step(OP_LW, 1'b0, 1'b0, e_immex(), "rst_lw_memadr");
        step(OP_LW, 1'b0, 1'b0, e_mem(1'b0), "rst_lw_memrd");
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        exp_q.push_back(e_idle());
        name_q.push_back("reset_mid_memrd");
        release_pending = 1'b1;
        fetch(OP_ADD, 0);
        step(OP_ADD, 1'b0, 1'b0, e_decode(), "post_rst_decode");
        step(OP_ADD, 1'b0, 1'b0, e_exec(4'b0010), "post_rst_exec");
        step(OP_ADD, 1'b0, 1'b0, e_aluwb(), "post_rst_aluwb");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
